// File: rtl/shim_integ_window_ctrl_if.sv
// Sample bus feeding the over-current integrator: at most one signed sample per cycle,
// tagged with the channel it belongs to.
interface shim_integ_window_ctrl_if #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SAMPLE_W = 16
) ();
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic                       sample_valid;
    logic [CH_W-1:0]            sample_ch;
    logic signed [SAMPLE_W-1:0] sample_data;

    modport master (
        output sample_valid,
        output sample_ch,
        output sample_data
    );

    modport slave (
        input sample_valid,
        input sample_ch,
        input sample_data
    );
endinterface

// File: rtl/shim_integ_window_ctrl.sv
// Windowed |sample| integrator: sums each channel over fixed windows, then checks the sums
// one channel per cycle against thresh_avg*window and latches a sticky per-channel fault.
module shim_integ_window_ctrl #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ACC_W    = 48
) (
    input  logic                  i_spi_clk,
    input  logic                  i_sync_reset,
    input  logic                  i_spi_en,
    input  logic                  i_integ_en,
    input  logic [31:0]           i_integ_window,
    input  logic [14:0]           i_integ_thresh_avg,
    shim_integ_window_ctrl_if.slave i_smp,
    output logic                  o_window_done,
    output logic                  o_over_thresh,
    output logic [NUM_CH-1:0]     o_over_thresh_ch,
    output logic                  o_cfg_err,
    output logic [1:0]            o_state
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StRun   = 2'd2,
        StFault = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_win;
    logic [31:0]         r_cnt;
    logic [ACC_W-1:0]    r_limit;
    logic [ACC_W-1:0]    r_acc  [NUM_CH];
    logic [ACC_W-1:0]    r_snap [NUM_CH];
    logic                r_chk_active;
    logic [CH_W-1:0]     r_chk_idx;
    logic [NUM_CH-1:0]   r_flags;
    logic                r_window_done;
    logic                r_over_thresh;
    logic [NUM_CH-1:0]   r_over_thresh_ch;
    logic                r_cfg_err;

    logic [SAMPLE_W-1:0] w_raw;
    logic [SAMPLE_W-1:0] w_abs;
    logic [ACC_W-1:0]    w_abs_ext;
    logic [46:0]         w_prod;
    logic [ACC_W-1:0]    w_limit;
    logic                w_win_end;
    logic [ACC_W-1:0]    w_acc_next [NUM_CH];
    logic                w_flag;
    logic                w_last;
    logic [NUM_CH-1:0]   w_flags_all;

    // Two's-complement magnitude; the most negative sample maps to 2^(SAMPLE_W-1) unsigned.
    assign w_raw     = $unsigned(i_smp.sample_data);
    assign w_abs     = w_raw[SAMPLE_W-1] ? (~w_raw + 1'b1) : w_raw;
    assign w_abs_ext = ACC_W'(w_abs);

    assign w_prod    = 47'(i_integ_thresh_avg) * 47'(i_integ_window);
    assign w_limit   = ACC_W'(w_prod);
    assign w_win_end = (r_cnt == (r_win - 32'd1));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_acc_next[i] = r_acc[i];
            if (i_smp.sample_valid && (i_smp.sample_ch == CH_W'(i))) begin
                w_acc_next[i] = r_acc[i] + w_abs_ext;
            end
        end
    end

    assign w_flag      = (r_snap[r_chk_idx] > r_limit);
    assign w_last      = (r_chk_idx == CH_W'(NUM_CH - 1));
    assign w_flags_all = r_flags | (NUM_CH'(w_flag) << r_chk_idx);

    always_ff @(posedge i_spi_clk or posedge i_sync_reset) begin
        if (i_sync_reset) begin
            r_state          <= StIdle;
            r_win            <= '0;
            r_cnt            <= '0;
            r_limit          <= '0;
            r_chk_active     <= 1'b0;
            r_chk_idx        <= '0;
            r_flags          <= '0;
            r_window_done    <= 1'b0;
            r_over_thresh    <= 1'b0;
            r_over_thresh_ch <= '0;
            r_cfg_err        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_window_done <= 1'b0;
            if (!i_spi_en) begin
                r_state          <= StIdle;
                r_chk_active     <= 1'b0;
                r_over_thresh    <= 1'b0;
                r_over_thresh_ch <= '0;
                r_cfg_err        <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_chk_active <= 1'b0;
                        if (i_integ_en) begin
                            r_state <= StArm;
                        end
                    end
                    StArm: begin
                        r_win        <= i_integ_window;
                        r_limit      <= w_limit;
                        r_cnt        <= '0;
                        r_chk_active <= 1'b0;
                        r_chk_idx    <= '0;
                        r_flags      <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                        if (i_integ_window < 32'(NUM_CH + 2)) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= StFault;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                    StRun: begin
                        if (!i_integ_en) begin
                            r_state      <= StIdle;
                            r_chk_active <= 1'b0;
                        end else begin
                            // The sample arriving on the last cycle still belongs to this window.
                            if (w_win_end) begin
                                r_cnt        <= '0;
                                r_chk_active <= 1'b1;
                                r_chk_idx    <= '0;
                                r_flags      <= '0;
                                for (int i = 0; i < NUM_CH; i++) begin
                                    r_snap[i] <= w_acc_next[i];
                                    r_acc[i]  <= '0;
                                end
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                                for (int i = 0; i < NUM_CH; i++) begin
                                    r_acc[i] <= w_acc_next[i];
                                end
                            end
                            // Window length >= NUM_CH+2, so a check never overlaps the next end.
                            if (r_chk_active) begin
                                if (w_last) begin
                                    r_chk_active  <= 1'b0;
                                    r_window_done <= 1'b1;
                                    if (|w_flags_all) begin
                                        r_over_thresh    <= 1'b1;
                                        r_over_thresh_ch <= r_over_thresh_ch | w_flags_all;
                                        r_state          <= StFault;
                                    end
                                end else begin
                                    r_chk_idx <= r_chk_idx + 1'b1;
                                    r_flags   <= w_flags_all;
                                end
                            end
                        end
                    end
                    StFault: begin
                        r_chk_active <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_window_done    = r_window_done;
    assign o_over_thresh    = r_over_thresh;
    assign o_over_thresh_ch = r_over_thresh_ch;
    assign o_cfg_err        = r_cfg_err;
    assign o_state          = r_state;
endmodule

// File: tb/tb_shim_integ_window_ctrl.sv
// Bench for shim_integ_window_ctrl: vector table of single-window cases, hand-written
// multi-cycle sequences, and randomized windows checked against a per-window sum model.
module tb_shim_integ_window_ctrl;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 48;
    localparam int CH_W     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              spi_en = 1'b0;
    logic              integ_en = 1'b0;
    logic [31:0]       win = '0;
    logic [14:0]       thr = '0;
    logic              window_done;
    logic              over;
    logic [NUM_CH-1:0] over_ch;
    logic              cfg_err;
    logic [1:0]        state;

    shim_integ_window_ctrl_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) smp ();

    shim_integ_window_ctrl #(
        .NUM_CH  (NUM_CH),
        .SAMPLE_W(SAMPLE_W),
        .ACC_W   (ACC_W)
    ) dut (
        .i_spi_clk         (clk),
        .i_sync_reset      (rst),
        .i_spi_en          (spi_en),
        .i_integ_en        (integ_en),
        .i_integ_window    (win),
        .i_integ_thresh_avg(thr),
        .i_smp             (smp),
        .o_window_done     (window_done),
        .o_over_thresh     (over),
        .o_over_thresh_ch  (over_ch),
        .o_cfg_err         (cfg_err),
        .o_state           (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int thr;
        int ch;
        int fill;
        int last;
        bit cfg;
        bit flt;
        int mask;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int d);
        smp.sample_valid = v;
        smp.sample_ch    = CH_W'(ch);
        smp.sample_data  = SAMPLE_W'(d);
    endtask

    task automatic go_idle();
        spi_en   = 1'b0;
        integ_en = 1'b0;
        drive(1'b0, 0, 0);
        tick();
        tick();
    endtask

    // Leaves the bench at the first post-ARM cycle; config inputs are then scrambled.
    task automatic arm(input int w, input int t);
        spi_en   = 1'b1;
        integ_en = 1'b1;
        win      = 32'(w);
        thr      = 15'(t);
        tick();
        check("arm_state", state, 1);
        tick();
        win = 32'd3;
        thr = ~15'(t);
    endtask

    function automatic longint absv(input logic signed [SAMPLE_W-1:0] d);
        return (d < 0) ? -longint'(d) : longint'(d);
    endfunction

    vec_t   tbl[9];
    longint sums[8][NUM_CH];

    initial begin
        int     n;
        int     seen;
        int     w;
        int     t;
        longint lim;
        longint m;
        longint exp_mask;
        bit     faulted;
        bit     done_exp;
        int     post;

        tbl[0] = '{16, 100,   3,    100,    100, 1'b0, 1'b0, 'h00};
        tbl[1] = '{16, 100,   5,    100,   -101, 1'b0, 1'b1, 'h20};
        tbl[2] = '{5,  100,   0,      0,      0, 1'b1, 1'b0, 'h00};
        tbl[3] = '{10, 0,     0,      0, -32768, 1'b0, 1'b1, 'h01};
        tbl[4] = '{10, 0,     6,      0,      0, 1'b0, 1'b0, 'h00};
        tbl[5] = '{9,  100,   0,      0,      0, 1'b1, 1'b0, 'h00};
        tbl[6] = '{12, 1000,  7,  -1000,  -1000, 1'b0, 1'b0, 'h00};
        tbl[7] = '{12, 999,   7,   1000,   1000, 1'b0, 1'b1, 'h80};
        tbl[8] = '{16, 32767, 1, -32768, -32768, 1'b0, 1'b1, 'h02};

        drive(1'b0, 0, 0);
        #3;
        check("reset_state", state, 0);
        check("reset_flags", {window_done, over, cfg_err}, 0);
        check("reset_mask", over_ch, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_state", state, 0);

        for (int r = 0; r < 9; r++) begin
            go_idle();
            arm(tbl[r].w, tbl[r].thr);
            if (tbl[r].cfg) begin
                check($sformatf("v%0d_cfg_err", r), cfg_err, 1);
                check($sformatf("v%0d_cfg_state", r), state, 3);
                check($sformatf("v%0d_cfg_over", r), {over, over_ch}, 0);
                tick();
                check($sformatf("v%0d_cfg_hold", r), state, 3);
            end else begin
                check($sformatf("v%0d_run", r), state, 2);
                for (int i = 0; i < tbl[r].w; i++) begin
                    drive(1'b1, tbl[r].ch, (i == tbl[r].w - 1) ? tbl[r].last : tbl[r].fill);
                    tick();
                end
                drive(1'b0, 0, 0);
                n = 0;
                while (!window_done && n < 40) begin
                    tick();
                    n++;
                end
                check($sformatf("v%0d_done_lat", r), n, NUM_CH);
                check($sformatf("v%0d_over", r), over, tbl[r].flt);
                check($sformatf("v%0d_mask", r), over_ch, tbl[r].mask);
                check($sformatf("v%0d_state", r), state, tbl[r].flt ? 3 : 2);
                tick();
                check($sformatf("v%0d_pulse", r), window_done, 0);
            end
            spi_en = 1'b0;
            tick();
            check($sformatf("v%0d_clear", r), {cfg_err, over, over_ch, state}, 0);
        end

        // Back-to-back windows: window 1 empty, window 2 carries the most negative sample.
        go_idle();
        arm(10, 0);
        for (int i = 0; i < 2 * 10 + NUM_CH; i++) begin
            drive(i == 13, 0, -32768);
            tick();
            if (i + 1 == 10 + NUM_CH) begin
                check("b2b_w1_done", window_done, 1);
                check("b2b_w1_clean", {over, state}, 2);
            end
            if (i + 1 == 20 + NUM_CH) begin
                check("b2b_w2_done", window_done, 1);
                check("b2b_w2_over", over, 1);
                check("b2b_w2_mask", over_ch, 'h01);
                check("b2b_w2_state", state, 3);
            end
        end
        drive(1'b0, 0, 0);
        integ_en = 1'b0;
        tick();
        check("fault_holds_integ_off", {over, state}, 7);
        spi_en = 1'b0;
        tick();
        check("both_low_clears", {over, over_ch, state}, 0);

        // integ_en dropped while the checks of window 1 are in flight.
        go_idle();
        arm(12, 0);
        for (int i = 0; i < 14; i++) begin
            drive(i == 0, 2, 5);
            tick();
        end
        integ_en = 1'b0;
        tick();
        check("abort_idle", state, 0);
        seen = 0;
        for (int i = 0; i < NUM_CH + 3; i++) begin
            tick();
            if (window_done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_no_fault", {over, over_ch}, 0);
        win      = 32'd12;
        integ_en = 1'b1;
        tick();
        check("rearm_arm", state, 1);
        tick();
        check("rearm_run", state, 2);

        // Async reset mid-RUN with a snapshot waiting to be checked.
        go_idle();
        arm(10, 0);
        for (int i = 0; i < 11; i++) begin
            drive(i < 10, 1, 7);
            tick();
        end
        drive(1'b0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("areset_now", {window_done, over, over_ch, cfg_err, state}, 0);
        integ_en = 1'b0;
        rst      = 1'b0;
        seen     = 0;
        for (int i = 0; i < NUM_CH + 3; i++) begin
            tick();
            if (window_done || over) seen = 1;
        end
        check("areset_idle", state, 0);
        check("areset_discard", seen, 0);

        // Async reset while faulted clears sticky outputs immediately.
        go_idle();
        arm(10, 0);
        for (int i = 0; i < 10 + NUM_CH; i++) begin
            drive(i == 0, 4, 1);
            tick();
        end
        drive(1'b0, 0, 0);
        check("fr_fault", {over, over_ch, state}, {1'b1, 8'h10, 2'd3});
        #2;
        rst = 1'b1;
        #1;
        check("fr_cleared", {over, over_ch, state}, 0);
        rst = 1'b0;
        tick();

        // Randomized windows against a per-window sum model.
        for (int trial = 0; trial < 6; trial++) begin
            go_idle();
            w = $urandom_range(10, 20);
            t = $urandom_range(0, 1500);
            arm(w, t);
            check("rnd_run", state, 2);
            lim      = longint'(t) * longint'(w);
            exp_mask = 0;
            faulted  = 0;
            post     = 0;
            for (int a = 0; a < 8; a++)
                for (int c = 0; c < NUM_CH; c++) sums[a][c] = 0;
            for (int i = 0; i < 6 * w + NUM_CH + 1; i++) begin
                if (!faulted) begin
                    int c;
                    int d;
                    bit v;
                    v = $urandom_range(0, 1);
                    c = $urandom_range(0, NUM_CH - 1);
                    d = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535));
                    drive(v, c, d);
                    if (v) sums[i / w][c] += absv(SAMPLE_W'(d));
                end else begin
                    drive(1'b0, 0, 0);
                end
                tick();
                n        = i + 1;
                done_exp = !faulted && (n > NUM_CH) && ((n - NUM_CH) % w == 0);
                if (done_exp) begin
                    m = 0;
                    for (int c = 0; c < NUM_CH; c++)
                        if (sums[(n - NUM_CH) / w - 1][c] > lim) m |= (64'd1 << c);
                    exp_mask |= m;
                    if (m != 0) faulted = 1;
                end
                check("rnd_done", window_done, done_exp);
                check("rnd_state", state, faulted ? 3 : 2);
                check("rnd_over", over, faulted);
                check("rnd_mask", over_ch, exp_mask);
                if (faulted) post++;
                if (post > 3) break;
            end
        end
        drive(1'b0, 0, 0);
        spi_en = 1'b0;
        tick();
        check("final_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
